rx_framing_parser: RTL and testbench
====================================

Name: rx_framing_parser

Overview:
- Sits directly downstream of the lane management/unstriping stage in the PCIe RX path. Consumes its 64-byte beat (data, per-byte K flags, valid).
- For Gen1/Gen2 (8b/10b) traffic, scans each beat for framing K-symbols and produces per-byte packet masks for the data link layer: TLP start, DLLP start, end, nullify, and in-packet.
- Tracks packet state across beats and flags framing errors.
- For Gen3+ it is a registered pass-through with all masks zero.

Parameters:
- DATA_BYTES, 64, bytes per beat; data width = 8*DATA_BYTES.
- K_STP, 8'hFB, K27.7 TLP start.
- K_SDP, 8'h5C, K28.2 DLLP start.
- K_END, 8'hFD, K29.7 good end.
- K_EDB, 8'hFE, K30.7 nullified end.

Ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- GEN  in  3  link generation (1..5)
- in_valid  in  1  beat valid from unstriping stage
- in_data  in  8*DATA_BYTES  beat bytes; byte i = in_data[8i+7:8i]; byte 0 earliest
- in_datak  in  DATA_BYTES  K flag per byte
- out_valid  out  1  registered in_valid
- out_data  out  8*DATA_BYTES  registered in_data
- out_datak  out  DATA_BYTES  registered in_datak
- sop_tlp_mask  out  DATA_BYTES  byte is an accepted STP
- sop_dllp_mask  out  DATA_BYTES  byte is an accepted SDP
- eop_mask  out  DATA_BYTES  byte is an END closing a packet
- nullify_mask  out  DATA_BYTES  byte is an EDB closing a TLP
- pkt_mask  out  DATA_BYTES  byte lies inside a packet, framing symbols included
- framing_err  out  1  one-cycle pulse, at least one framing violation in the beat
- pkt_state  out  2  state after last processed byte (0 IDLE, 1 IN_TLP, 2 IN_DLLP)

Behaviour:
- Reset (async, active-low): every output 0; state IDLE.
- Latency: exactly 1 clk. All outputs are registered together from the same input beat.
- in_valid=0: out_valid=0, masks 0, framing_err 0; carried state unchanged; out_data/out_datak hold their previous values.
- GEN>=3: pass-through. Masks 0, framing_err 0, state forced IDLE.
- GEN 1/2, per-byte scan from byte 0 to byte DATA_BYTES-1; state carries byte to byte and beat to beat:
  - IDLE:
    - K STP: sop_tlp, pkt, go to IN_TLP.
    - K SDP: sop_dllp, pkt, go to IN_DLLP.
    - K END or K EDB: error, stay IDLE.
    - Any other byte (idle data, COM, SKP, PAD): ignored.
  - IN_TLP/IN_DLLP:
    - Non-K byte: pkt.
    - K END: eop, pkt, go to IDLE.
    - K EDB in IN_TLP: nullify, pkt, go to IDLE.
    - K EDB in IN_DLLP: error, go to IDLE, pkt=0.
    - K STP/SDP: error (previous packet aborted, no eop); the new start is accepted as in IDLE.
    - Any other K: error, go to IDLE, pkt=0.
- A packet may span any number of beats. Several packets may start and end in one beat.
- A GEN change while not IDLE: the first beat processed under the new GEN resets state to IDLE with no error.
- The scan is a combinational chain across DATA_BYTES. Only the final state is registered.

Optional Feature:
- Macro: RX_FRAMING_ERRCNT_EN.
- Defined:
  - Adds output err_count [15:0], which increments by 1 on each beat with framing_err=1.
  - Saturates at 16'hFFFF.
  - Reset value 0.
  - Adds input err_count_clr (1 bit), synchronous clear that takes priority over increment.
- Undefined: neither port exists, no counter logic.

Decomposition:
- Shared package rx_pkg:
  - K-symbol constants (STP, SDP, END, EDB, COM, SKP, PAD).
  - State encoding: IDLE, IN_TLP, IN_DLLP.
  - GEN encodings.
  - DATA_BYTES default.
- Natural sub-module: rx_framing_byte_step.
  - Combinational: (state_in, byte, k) -> (state_out, sop_tlp, sop_dllp, eop, nullify, pkt, err).
  - Instantiated DATA_BYTES times in a chain inside rx_framing_parser.

Test Plan:
- GEN=1, beat with byte0=K FB, bytes1-10 data, byte11=K FD, rest non-K 00 -> next clk: sop_tlp_mask bit0, eop_mask bit11, pkt_mask=0x0FFF, framing_err=0, pkt_state=0.
- GEN=2, beat1 byte60=K 5C, bytes61-63 data; beat2 bytes0-3 data, byte4=K FD -> beat1 pkt_mask bits60-63 with pkt_state=2; beat2 eop bit4, pkt_mask=0x1F, pkt_state=0.
- GEN=1, byte0=K FB, byte5=K FB, byte9=K FD -> sop_tlp bits0 and 5, eop bit9, framing_err=1 for one clk.
- GEN=1, byte0=K 5C, byte3=K FE -> nullify_mask=0, framing_err=1, pkt_mask=0x7, pkt_state=0. Repeat with K FB -> nullify bit3, no error.
- GEN=4, beat with K FB at byte0 -> all masks 0, framing_err 0, out_data equals in_data after 1 clk. Assert reset mid-packet (state IN_TLP) -> all outputs 0 immediately, state IDLE.
- With RX_FRAMING_ERRCNT_EN: 3 error beats -> err_count=3. Assert err_count_clr on the same cycle as an error beat -> err_count=0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and types for the PCIe RX framing parser.
package rx_pkg;

  localparam int unsigned DATA_BYTES_DEF = 64;

  // 8b/10b framing and ordered-set K-symbols.
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_TLP  = 2'd1,
    ST_IN_DLLP = 2'd2
  } state_t;

  // Only Gen1/Gen2 carry 8b/10b framing symbols.
  function automatic logic is_8b10b(input logic [2:0] gen);
    return (gen == GEN1) || (gen == GEN2);
  endfunction

endpackage

// File: rtl/rx_framing_byte_step.sv
// One byte of the framing scan: next state and per-byte mask bits.
module rx_framing_byte_step
  import rx_pkg::*;
(
  input  state_t     i_state,
  input  logic [7:0] i_byte,
  input  logic       i_k,
  output state_t     o_state,
  output logic       o_sop_tlp,
  output logic       o_sop_dllp,
  output logic       o_eop,
  output logic       o_nullify,
  output logic       o_pkt,
  output logic       o_err
);

  always_comb begin
    o_state    = i_state;
    o_sop_tlp  = 1'b0;
    o_sop_dllp = 1'b0;
    o_eop      = 1'b0;
    o_nullify  = 1'b0;
    o_pkt      = 1'b0;
    o_err      = 1'b0;
    if (!i_k) begin
      o_pkt = (i_state != ST_IDLE);
    end else if (i_byte == K_STP) begin
      // A start inside a packet aborts the old one but is still accepted.
      o_err     = (i_state != ST_IDLE);
      o_sop_tlp = 1'b1;
      o_pkt     = 1'b1;
      o_state   = ST_IN_TLP;
    end else if (i_byte == K_SDP) begin
      o_err      = (i_state != ST_IDLE);
      o_sop_dllp = 1'b1;
      o_pkt      = 1'b1;
      o_state    = ST_IN_DLLP;
    end else if (i_state == ST_IDLE) begin
      o_err = (i_byte == K_END) || (i_byte == K_EDB);
    end else if (i_byte == K_END) begin
      o_eop   = 1'b1;
      o_pkt   = 1'b1;
      o_state = ST_IDLE;
    end else if ((i_byte == K_EDB) && (i_state == ST_IN_TLP)) begin
      o_nullify = 1'b1;
      o_pkt     = 1'b1;
      o_state   = ST_IDLE;
    end else begin
      o_err   = 1'b1;
      o_state = ST_IDLE;
    end
  end

endmodule

// File: rtl/rx_framing_parser.sv
// PCIe RX framing parser: per-byte packet masks for Gen1/2, pass-through for Gen3+.
// Optional error counter enabled by defining RX_FRAMING_ERRCNT_EN.
module rx_framing_parser
  import rx_pkg::*;
#(
  parameter int unsigned DATA_BYTES = DATA_BYTES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              GEN,
  input  logic                    in_valid,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_datak,
  output logic                    out_valid,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic [DATA_BYTES-1:0]   out_datak,
  output logic [DATA_BYTES-1:0]   sop_tlp_mask,
  output logic [DATA_BYTES-1:0]   sop_dllp_mask,
  output logic [DATA_BYTES-1:0]   eop_mask,
  output logic [DATA_BYTES-1:0]   nullify_mask,
  output logic [DATA_BYTES-1:0]   pkt_mask,
  output logic                    framing_err,
  output logic [1:0]              pkt_state
`ifdef RX_FRAMING_ERRCNT_EN
  ,
  input  logic                    err_count_clr,
  output logic [15:0]             err_count
`endif
);

  state_t                  r_state;
  logic [2:0]              r_gen_prev;
  logic                    r_valid;
  logic [8*DATA_BYTES-1:0] r_data;
  logic [DATA_BYTES-1:0]   r_datak;
  logic [DATA_BYTES-1:0]   r_sop_tlp;
  logic [DATA_BYTES-1:0]   r_sop_dllp;
  logic [DATA_BYTES-1:0]   r_eop;
  logic [DATA_BYTES-1:0]   r_nullify;
  logic [DATA_BYTES-1:0]   r_pkt;
  logic                    r_err;

  state_t                  w_chain [DATA_BYTES+1];
  logic [DATA_BYTES-1:0]   w_sop_tlp;
  logic [DATA_BYTES-1:0]   w_sop_dllp;
  logic [DATA_BYTES-1:0]   w_eop;
  logic [DATA_BYTES-1:0]   w_nullify;
  logic [DATA_BYTES-1:0]   w_pkt;
  logic [DATA_BYTES-1:0]   w_err;
  logic                    w_framed;
  logic                    w_beat_err;

  // A generation change drops any packet in flight without flagging it.
  assign w_chain[0]  = (GEN != r_gen_prev) ? ST_IDLE : r_state;
  assign w_framed    = is_8b10b(GEN);
  assign w_beat_err  = in_valid && w_framed && (|w_err);

  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_step
    rx_framing_byte_step u_step (
      .i_state    (w_chain[gi]),
      .i_byte     (in_data[8*gi +: 8]),
      .i_k        (in_datak[gi]),
      .o_state    (w_chain[gi+1]),
      .o_sop_tlp  (w_sop_tlp[gi]),
      .o_sop_dllp (w_sop_dllp[gi]),
      .o_eop      (w_eop[gi]),
      .o_nullify  (w_nullify[gi]),
      .o_pkt      (w_pkt[gi]),
      .o_err      (w_err[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_gen_prev <= 3'd0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_datak    <= '0;
      r_sop_tlp  <= '0;
      r_sop_dllp <= '0;
      r_eop      <= '0;
      r_nullify  <= '0;
      r_pkt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_valid    <= in_valid;
      r_sop_tlp  <= '0;
      r_sop_dllp <= '0;
      r_eop      <= '0;
      r_nullify  <= '0;
      r_pkt      <= '0;
      r_err      <= 1'b0;
      if (in_valid) begin
        r_data     <= in_data;
        r_datak    <= in_datak;
        r_gen_prev <= GEN;
        if (w_framed) begin
          r_sop_tlp  <= w_sop_tlp;
          r_sop_dllp <= w_sop_dllp;
          r_eop      <= w_eop;
          r_nullify  <= w_nullify;
          r_pkt      <= w_pkt;
          r_err      <= |w_err;
          r_state    <= w_chain[DATA_BYTES];
        end else begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_data      = r_data;
  assign out_datak     = r_datak;
  assign sop_tlp_mask  = r_sop_tlp;
  assign sop_dllp_mask = r_sop_dllp;
  assign eop_mask      = r_eop;
  assign nullify_mask  = r_nullify;
  assign pkt_mask      = r_pkt;
  assign framing_err   = r_err;
  assign pkt_state     = r_state;

`ifdef RX_FRAMING_ERRCNT_EN
  logic [15:0] r_err_count;

  // Counts in step with framing_err; clear wins and the count saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= 16'd0;
    end else if (err_count_clr) begin
      r_err_count <= 16'd0;
    end else if (w_beat_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_rx_framing_parser.sv
// Randomized self-checking bench for rx_framing_parser with a byte-list reference model.
module tb_rx_framing_parser;

  localparam int unsigned DB = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        gen;
  logic              in_valid;
  logic [8*DB-1:0]   in_data;
  logic [DB-1:0]     in_datak;
  logic              out_valid;
  logic [8*DB-1:0]   out_data;
  logic [DB-1:0]     out_datak;
  logic [DB-1:0]     sop_tlp_mask, sop_dllp_mask, eop_mask, nullify_mask, pkt_mask;
  logic              framing_err;
  logic [1:0]        pkt_state;
`ifdef RX_FRAMING_ERRCNT_EN
  logic              clr;
  logic [15:0]       err_count;
  int                m_errcnt;
`endif

  rx_framing_parser dut (
    .clk           (clk),
    .reset         (reset),
    .GEN           (gen),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_datak      (in_datak),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_datak     (out_datak),
    .sop_tlp_mask  (sop_tlp_mask),
    .sop_dllp_mask (sop_dllp_mask),
    .eop_mask      (eop_mask),
    .nullify_mask  (nullify_mask),
    .pkt_mask      (pkt_mask),
    .framing_err   (framing_err),
    .pkt_state     (pkt_state)
`ifdef RX_FRAMING_ERRCNT_EN
    ,
    .err_count_clr (clr),
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: open packet kind (0 none, 1 TLP, 2 DLLP) and last GEN seen.
  int              m_open;
  int              m_gen;
  logic            e_valid;
  logic [8*DB-1:0] e_data;
  logic [DB-1:0]   e_datak, e_sopt, e_sopd, e_eop, e_null, e_pkt;
  logic            e_err;

  logic [8*DB-1:0] d;
  logic [DB-1:0]   k;
  logic [7:0]      ksyms [7];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic clear_beat();
    d = '0;
    k = '0;
  endtask

  task automatic put(input int idx, input logic [7:0] val, input logic isk);
    d[8*idx +: 8] = val;
    k[idx]        = isk;
  endtask

  task automatic model_reset();
    m_open = 0; m_gen = 0;
    e_valid = 1'b0; e_data = '0; e_datak = '0;
    e_sopt = '0; e_sopd = '0; e_eop = '0; e_null = '0; e_pkt = '0; e_err = 1'b0;
`ifdef RX_FRAMING_ERRCNT_EN
    m_errcnt = 0;
`endif
  endtask

  task automatic model_beat(input int g, input logic v, input logic c);
    logic [7:0] b;
    int open;
    e_sopt = '0; e_sopd = '0; e_eop = '0; e_null = '0; e_pkt = '0; e_err = 1'b0;
    e_valid = v;
    if (v) begin
      e_data  = d;
      e_datak = k;
      if (g == 1 || g == 2) begin
        open = (g == m_gen) ? m_open : 0;
        for (int i = 0; i < int'(DB); i++) begin
          b = d[8*i +: 8];
          if (!k[i]) begin
            if (open != 0) e_pkt[i] = 1'b1;
            continue;
          end
          if (b == 8'hFB || b == 8'h5C) begin
            if (open != 0) e_err = 1'b1;
            if (b == 8'hFB) e_sopt[i] = 1'b1; else e_sopd[i] = 1'b1;
            e_pkt[i] = 1'b1;
            open = (b == 8'hFB) ? 1 : 2;
          end else if (open == 0) begin
            if (b == 8'hFD || b == 8'hFE) e_err = 1'b1;
          end else if (b == 8'hFD) begin
            e_eop[i] = 1'b1; e_pkt[i] = 1'b1; open = 0;
          end else if (b == 8'hFE && open == 1) begin
            e_null[i] = 1'b1; e_pkt[i] = 1'b1; open = 0;
          end else begin
            e_err = 1'b1; open = 0;
          end
        end
        m_open = open;
      end else begin
        m_open = 0;
      end
      m_gen = g;
    end
`ifdef RX_FRAMING_ERRCNT_EN
    if (c) m_errcnt = 0;
    else if (e_err && m_errcnt < 65535) m_errcnt++;
`else
    if (c) e_err = e_err;
`endif
  endtask

  // Drive one beat, advance one clock, compare everything with the model.
  task automatic beat(input int g, input logic v, input logic c, input string tag);
    gen = 3'(g); in_valid = v; in_data = d; in_datak = k;
`ifdef RX_FRAMING_ERRCNT_EN
    clr = c;
`endif
    model_beat(g, v, c);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 512'(out_valid),     512'(e_valid));
    check({tag, ".data"},  512'(out_data),      512'(e_data));
    check({tag, ".datak"}, 512'(out_datak),     512'(e_datak));
    check({tag, ".sopt"},  512'(sop_tlp_mask),  512'(e_sopt));
    check({tag, ".sopd"},  512'(sop_dllp_mask), 512'(e_sopd));
    check({tag, ".eop"},   512'(eop_mask),      512'(e_eop));
    check({tag, ".null"},  512'(nullify_mask),  512'(e_null));
    check({tag, ".pkt"},   512'(pkt_mask),      512'(e_pkt));
    check({tag, ".err"},   512'(framing_err),   512'(e_err));
    check({tag, ".state"}, 512'(pkt_state),     512'(m_open));
`ifdef RX_FRAMING_ERRCNT_EN
    check({tag, ".errcnt"}, 512'(err_count),    512'(m_errcnt));
    clr = 1'b0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 512'(out_valid), 512'(0));
    check({tag, ".data"},  512'(out_data),  512'(0));
    check({tag, ".datak"}, 512'(out_datak), 512'(0));
    check({tag, ".masks"}, 512'(sop_tlp_mask | sop_dllp_mask | eop_mask | nullify_mask | pkt_mask), 512'(0));
    check({tag, ".err"},   512'(framing_err), 512'(0));
    check({tag, ".state"}, 512'(pkt_state),   512'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    int g;
    ksyms[0] = 8'hFB; ksyms[1] = 8'h5C; ksyms[2] = 8'hFD; ksyms[3] = 8'hFE;
    ksyms[4] = 8'hBC; ksyms[5] = 8'h1C; ksyms[6] = 8'hF7;
    reset = 1'b0; gen = 3'd1; in_valid = 1'b0; in_data = '0; in_datak = '0;
`ifdef RX_FRAMING_ERRCNT_EN
    clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
`ifdef RX_FRAMING_ERRCNT_EN
    check("reset.errcnt", 512'(err_count), 512'(0));
`endif
    @(negedge clk);
    reset = 1'b1;

    // Single TLP inside one beat.
    clear_beat();
    put(0, 8'hFB, 1'b1);
    for (int i = 1; i <= 10; i++) put(i, 8'($urandom), 1'b0);
    put(11, 8'hFD, 1'b1);
    beat(1, 1'b1, 1'b0, "tlp1");
    check("tlp1.pkt_const", 512'(pkt_mask), 512'(64'h0FFF));
    check("tlp1.eop_const", 512'(eop_mask), 512'(64'h0800));

    // DLLP spanning two beats.
    clear_beat();
    put(60, 8'h5C, 1'b1);
    for (int i = 61; i < 64; i++) put(i, 8'($urandom), 1'b0);
    beat(2, 1'b1, 1'b0, "span1");
    check("span1.pkt_const", 512'(pkt_mask), 512'(64'hF000_0000_0000_0000));
    check("span1.state_const", 512'(pkt_state), 512'(2));
    clear_beat();
    for (int i = 0; i < 4; i++) put(i, 8'($urandom), 1'b0);
    put(4, 8'hFD, 1'b1);
    beat(2, 1'b1, 1'b0, "span2");
    check("span2.pkt_const", 512'(pkt_mask), 512'(64'h1F));

    // Nested start aborts the first TLP.
    clear_beat();
    put(0, 8'hFB, 1'b1); put(5, 8'hFB, 1'b1); put(9, 8'hFD, 1'b1);
    beat(1, 1'b1, 1'b0, "abort");
    check("abort.sopt_const", 512'(sop_tlp_mask), 512'(64'h21));
    check("abort.err_const", 512'(framing_err), 512'(1));
    clear_beat();
    beat(1, 1'b1, 1'b0, "abort_next");

    // EDB closes a TLP but is illegal in a DLLP.
    clear_beat();
    put(0, 8'h5C, 1'b1); put(3, 8'hFE, 1'b1);
    beat(1, 1'b1, 1'b0, "edb_dllp");
    check("edb_dllp.pkt_const", 512'(pkt_mask), 512'(64'h7));
    clear_beat();
    put(0, 8'hFB, 1'b1); put(3, 8'hFE, 1'b1);
    beat(1, 1'b1, 1'b0, "edb_tlp");
    check("edb_tlp.null_const", 512'(nullify_mask), 512'(64'h8));

    // Invalid beat holds data, clears masks.
    clear_beat();
    put(0, 8'hFB, 1'b1);
    beat(1, 1'b0, 1'b0, "idle_gap");

`ifdef RX_FRAMING_ERRCNT_EN
    clear_beat();
    beat(1, 1'b1, 1'b1, "cnt_clr");
    for (int n = 0; n < 3; n++) begin
      clear_beat();
      put(7, 8'hFD, 1'b1);
      beat(1, 1'b1, 1'b0, "cnt_err");
    end
    check("cnt.three", 512'(err_count), 512'(3));
    beat(1, 1'b1, 1'b1, "cnt_clr_err");
    check("cnt.cleared", 512'(err_count), 512'(0));
`endif

    // Gen4 pass-through, then open a TLP and reset mid-packet.
    clear_beat();
    put(0, 8'hFB, 1'b1);
    for (int i = 1; i < 64; i++) put(i, 8'($urandom), 1'b0);
    beat(4, 1'b1, 1'b0, "gen4");
    check("gen4.data_const", 512'(out_data), 512'(d));
    beat(1, 1'b1, 1'b0, "open_tlp");
    check("open_tlp.state_const", 512'(pkt_state), 512'(1));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #1;
    reset = 1'b1;

    // Randomized traffic with occasional GEN changes and idle gaps.
    g = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 8) g = int'($urandom_range(1, 5));
      for (int i = 0; i < int'(DB); i++) begin
        if ($urandom_range(0, 99) < 10) put(i, ksyms[$urandom_range(0, 6)], 1'b1);
        else put(i, 8'($urandom), 1'b0);
      end
      beat(g, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
